hd44780_cmd_sequencer: RTL and testbench
========================================

Name: hd44780_cmd_sequencer

Overview:
Controller that owns the HD44780 nybble sender and the state timer and sequences them. After reset it runs the mandatory 4-bit power-on initialisation, then accepts byte commands/data over a valid/ready handshake. Each byte is split into high then low nybbles with the correct post-command delay. It sits between the wishbone syscon/state timer/nybble sender and any higher-level text or test logic in the top.

Parameters:
TIMER_BITS, 23, width of st_dat (matches `H4_TIMER_BITS).
DLY_100MS, 4800000, power-on wait in clock ticks.
DLY_4P1MS, 196800, wait after first 0x3 nybble.
DLY_100US, 4800, wait after later init nybbles.
DLY_53US, 2544, normal post-byte delay.
DLY_3MS, 144000, post-byte delay for clear/home.

Ports:
CLK_I  in  1  system clock (wishbone clock from syscon).
RST_I  in  1  reset, asynchronous, active-low (0 = reset).
cmd_dat  in  8  byte to send.
cmd_rs  in  1  RS for the byte (0 = instruction, 1 = data).
cmd_valid  in  1  requester has a byte.
cmd_ready  out  1  sequencer will accept a byte this cycle.
init_done  out  1  high once the init sequence completes; stays high until reset.
ns_dat  out  4  nybble to nybble sender.
ns_rs  out  1  RS to nybble sender.
ns_start_stb  out  1  one-cycle strobe to start a nybble.
ns_done_stb  in  1  one-cycle strobe from nybble sender when E cycle completes.
st_dat  out  TIMER_BITS  delay load value for state timer.
st_start_stb  out  1  one-cycle strobe to load/start the timer.
st_end_stb  in  1  one-cycle strobe when the timer expires.

Behaviour:
- Reset: all outputs 0, state PWR, step = 0. Reset asserted mid-operation aborts everything; on release the init sequence restarts from the 100ms wait.
- All outputs are registered. ns_dat, ns_rs and st_dat are driven in the same cycle as their strobe and are held until the next strobe.
- States: PWR, INIT_NYB, INIT_NYB_WAIT, INIT_DLY, IDLE, HI, HI_WAIT, LO, LO_WAIT, DLY, DLY_WAIT.
- PWR:
  - First cycle after reset release: st_start_stb = 1 with st_dat = DLY_100MS.
  - On st_end_stb, go to INIT_NYB.
- Init nybbles, step 0..3 (all with ns_rs = 0):
  - step 0: nybble 0x3, then DLY_4P1MS.
  - step 1: nybble 0x3, then DLY_100US.
  - step 2: nybble 0x3, then DLY_100US.
  - step 3: nybble 0x2, then DLY_100US.
  - Flow: INIT_NYB pulses ns_start_stb, INIT_NYB_WAIT waits for ns_done_stb, INIT_DLY starts the timer and waits for st_end_stb, then step++.
- Init bytes, step 4..8 (rs = 0): 0x28, 0x08, 0x01, 0x06, 0x0C. These go through the normal byte path HI..DLY_WAIT. After step 8 completes: set init_done = 1, go to IDLE.
- IDLE:
  - cmd_ready = 1 only in IDLE with init_done = 1.
  - On a rising edge where cmd_valid && cmd_ready: latch cmd_dat/cmd_rs, cmd_ready = 0 next cycle, go to HI.
  - cmd_valid while not ready is ignored, with no latching.
- Byte path:
  - HI: ns_start_stb with ns_dat = byte[7:4], ns_rs = rs.
  - HI_WAIT: wait for ns_done_stb.
  - LO: ns_start_stb with ns_dat = byte[3:0].
  - LO_WAIT: wait for ns_done_stb.
  - DLY: st_start_stb with st_dat = DLY_3MS if rs = 0 and byte ∈ {0x01, 0x02, 0x03}, else DLY_53US.
  - DLY_WAIT: wait for st_end_stb, then return to IDLE (or to the next init step).
- Latency: a handshake accepted at edge k gives ns_start_stb high in cycle k+1. cmd_ready returns high the cycle after st_end_stb.
- Strobes arriving in states not waiting for them are ignored. ns_done_stb and st_end_stb asserted together are evaluated only against the current state's wait condition.
- The block never asserts ns_start_stb and st_start_stb in the same cycle. Each strobe is exactly one cycle.
- There is no timeout: a missing done/end strobe leaves the FSM waiting indefinitely.

Test Plan:
1. Power-on with DLY_* = 20/8/4/3/6 and behavioural sender/timer models: verify the strobe order below, then init_done = 1 and cmd_ready = 1.
   - Timer loads 20; nybbles 3, 3, 3, 2 with loads 8, 4, 4, 4.
   - Nybble pairs 2/8, 0/8, 0/1, 0/6, 0/C with loads 3, 3, 6, 3, 3.
2. After init, send cmd_dat = 0x41, cmd_rs = 1 → ns_dat 4 then 1, ns_rs = 1, st_dat = 3, cmd_ready low until 1 cycle after st_end_stb.
3. Send 0x01 rs = 0 → st_dat = 6. Send 0x01 rs = 1 → st_dat = 3. Send 0x04 rs = 0 → st_dat = 3.
4. Hold cmd_valid high during init and while busy → no acceptance, no ns_start_stb. Hold it across a completion → the next byte is accepted on the first cycle cmd_ready = 1.
5. Assert RST_I low during HI_WAIT of the 0x06 init byte → all outputs 0 immediately (asynchronously). On release, the sequence restarts with st_dat = 20.
6. Inject a spurious st_end_stb during HI_WAIT and a spurious ns_done_stb during DLY_WAIT → no state advance, and the command stream is unchanged.

Source files
------------

// File: rtl/hd44780_cmd_sequencer.sv
// HD44780 command sequencer.
// Drives the nybble sender and the state timer. After reset it runs the
// 4-bit power-on initialisation (100ms wait, 0x3/0x3/0x3/0x2 nybbles, then
// the bytes 0x28 0x08 0x01 0x06 0x0C), after which it accepts bytes over a
// valid/ready handshake and sends each one as high then low nybble followed
// by the post-command delay.
//
// Ports:
//   CLK_I, RST_I             clock, asynchronous active-low reset
//   cmd_dat, cmd_rs          byte and RS from the requester
//   cmd_valid, cmd_ready     byte handshake (ready only when idle after init)
//   init_done                high once initialisation has finished
//   ns_dat, ns_rs            nybble and RS to the nybble sender
//   ns_start_stb             one-cycle start strobe to the nybble sender
//   ns_done_stb              one-cycle completion strobe from the sender
//   st_dat, st_start_stb     timer load value and one-cycle load strobe
//   st_end_stb               one-cycle expiry strobe from the timer
module hd44780_cmd_sequencer #(
  parameter int          TIMER_BITS = 23,
  parameter int unsigned DLY_100MS  = 4800000,
  parameter int unsigned DLY_4P1MS  = 196800,
  parameter int unsigned DLY_100US  = 4800,
  parameter int unsigned DLY_53US   = 2544,
  parameter int unsigned DLY_3MS    = 144000
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic [7:0]            cmd_dat,
  input  logic                  cmd_rs,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  init_done,
  output logic [3:0]            ns_dat,
  output logic                  ns_rs,
  output logic                  ns_start_stb,
  input  logic                  ns_done_stb,
  output logic [TIMER_BITS-1:0] st_dat,
  output logic                  st_start_stb,
  input  logic                  st_end_stb
);

  typedef enum logic [3:0] {
    PWR,
    INIT_NYB,
    INIT_NYB_WAIT,
    INIT_DLY,
    IDLE,
    HI,
    HI_WAIT,
    LO,
    LO_WAIT,
    DLY,
    DLY_WAIT
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            step, step_nxt;
  logic                  pwr_armed, pwr_armed_nxt;
  logic [7:0]            cur_byte, cur_byte_nxt;
  logic                  cur_rs, cur_rs_nxt;
  logic                  init_done_nxt;
  logic                  cmd_ready_nxt;
  logic [3:0]            ns_dat_nxt;
  logic                  ns_rs_nxt;
  logic                  ns_start_nxt;
  logic [TIMER_BITS-1:0] st_dat_nxt;
  logic                  st_start_nxt;

  // Initialisation bytes sent through the normal byte path, by step number.
  function automatic logic [7:0] init_byte(input logic [3:0] s);
    case (s)
      4'd4:    init_byte = 8'h28;
      4'd5:    init_byte = 8'h08;
      4'd6:    init_byte = 8'h01;
      4'd7:    init_byte = 8'h06;
      default: init_byte = 8'h0C;
    endcase
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long delay.
  function automatic logic [TIMER_BITS-1:0] byte_delay(input logic [7:0] b,
                                                       input logic       rs);
    if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03))
      byte_delay = TIMER_BITS'(DLY_3MS);
    else
      byte_delay = TIMER_BITS'(DLY_53US);
  endfunction

  // Strobe outputs are registered from the transition into their state, so
  // HI, LO, INIT_NYB and DLY are exactly the cycles the strobe is visible.
  // The wait states that follow can therefore never see a done/end strobe
  // belonging to the previous request.
  always_comb begin
    state_nxt     = state;
    step_nxt      = step;
    pwr_armed_nxt = pwr_armed;
    cur_byte_nxt  = cur_byte;
    cur_rs_nxt    = cur_rs;
    init_done_nxt = init_done;
    ns_dat_nxt    = ns_dat;
    ns_rs_nxt     = ns_rs;
    ns_start_nxt  = 1'b0;
    st_dat_nxt    = st_dat;
    st_start_nxt  = 1'b0;

    case (state)
      PWR: begin
        // First cycle out of reset loads the power-on wait, then waits for it.
        if (!pwr_armed) begin
          pwr_armed_nxt = 1'b1;
          st_start_nxt  = 1'b1;
          st_dat_nxt    = TIMER_BITS'(DLY_100MS);
        end else if (st_end_stb) begin
          state_nxt    = INIT_NYB;
          ns_start_nxt = 1'b1;
          ns_dat_nxt   = 4'h3;
          ns_rs_nxt    = 1'b0;
        end
      end

      INIT_NYB: state_nxt = INIT_NYB_WAIT;

      INIT_NYB_WAIT: begin
        if (ns_done_stb) begin
          state_nxt    = INIT_DLY;
          st_start_nxt = 1'b1;
          st_dat_nxt   = (step == 4'd0) ? TIMER_BITS'(DLY_4P1MS)
                                        : TIMER_BITS'(DLY_100US);
        end
      end

      INIT_DLY: begin
        if (st_end_stb) begin
          step_nxt = step + 4'd1;
          if (step == 4'd3) begin
            // Nybble phase over; first init byte goes through the byte path.
            state_nxt    = HI;
            cur_byte_nxt = init_byte(4'd4);
            cur_rs_nxt   = 1'b0;
            ns_start_nxt = 1'b1;
            ns_dat_nxt   = init_byte(4'd4) >> 4;
            ns_rs_nxt    = 1'b0;
          end else begin
            state_nxt    = INIT_NYB;
            ns_start_nxt = 1'b1;
            ns_dat_nxt   = (step == 4'd2) ? 4'h2 : 4'h3;
            ns_rs_nxt    = 1'b0;
          end
        end
      end

      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt    = HI;
          cur_byte_nxt = cmd_dat;
          cur_rs_nxt   = cmd_rs;
          ns_start_nxt = 1'b1;
          ns_dat_nxt   = cmd_dat[7:4];
          ns_rs_nxt    = cmd_rs;
        end
      end

      HI: state_nxt = HI_WAIT;

      HI_WAIT: begin
        if (ns_done_stb) begin
          state_nxt    = LO;
          ns_start_nxt = 1'b1;
          ns_dat_nxt   = cur_byte[3:0];
          ns_rs_nxt    = cur_rs;
        end
      end

      LO: state_nxt = LO_WAIT;

      LO_WAIT: begin
        if (ns_done_stb) begin
          state_nxt    = DLY;
          st_start_nxt = 1'b1;
          st_dat_nxt   = byte_delay(cur_byte, cur_rs);
        end
      end

      DLY: state_nxt = DLY_WAIT;

      DLY_WAIT: begin
        if (st_end_stb) begin
          if (init_done) begin
            state_nxt = IDLE;
          end else if (step == 4'd8) begin
            state_nxt     = IDLE;
            init_done_nxt = 1'b1;
          end else begin
            step_nxt     = step + 4'd1;
            state_nxt    = HI;
            cur_byte_nxt = init_byte(step + 4'd1);
            cur_rs_nxt   = 1'b0;
            ns_start_nxt = 1'b1;
            ns_dat_nxt   = init_byte(step + 4'd1) >> 4;
            ns_rs_nxt    = 1'b0;
          end
        end
      end

      default: state_nxt = PWR;
    endcase

    cmd_ready_nxt = (state_nxt == IDLE) && init_done_nxt;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state        <= PWR;
      step         <= 4'd0;
      pwr_armed    <= 1'b0;
      cur_byte     <= 8'h00;
      cur_rs       <= 1'b0;
      init_done    <= 1'b0;
      cmd_ready    <= 1'b0;
      ns_dat       <= 4'h0;
      ns_rs        <= 1'b0;
      ns_start_stb <= 1'b0;
      st_dat       <= '0;
      st_start_stb <= 1'b0;
    end else begin
      state        <= state_nxt;
      step         <= step_nxt;
      pwr_armed    <= pwr_armed_nxt;
      cur_byte     <= cur_byte_nxt;
      cur_rs       <= cur_rs_nxt;
      init_done    <= init_done_nxt;
      cmd_ready    <= cmd_ready_nxt;
      ns_dat       <= ns_dat_nxt;
      ns_rs        <= ns_rs_nxt;
      ns_start_stb <= ns_start_nxt;
      st_dat       <= st_dat_nxt;
      st_start_stb <= st_start_nxt;
    end
  end

endmodule

// File: tb/tb_hd44780_cmd_sequencer.sv
// Bench for hd44780_cmd_sequencer: behavioural nybble sender and timer
// models, a strobe logger, and an expected strobe stream built from the
// HD44780 init rules and the byte delay rules.
`timescale 1ns/1ps
module tb_hd44780_cmd_sequencer;
  localparam int TB_BITS = 23;
  localparam int D100MS = 20, D4P1 = 8, D100US = 4, D53 = 3, D3MS = 6;

  logic               CLK_I = 1'b0;
  logic               RST_I = 1'b0;
  logic [7:0]         cmd_dat = 8'h00;
  logic               cmd_rs = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready, init_done;
  logic [3:0]         ns_dat;
  logic               ns_rs, ns_start_stb, ns_done_stb;
  logic [TB_BITS-1:0] st_dat;
  logic               st_start_stb, st_end_stb;

  logic ns_done_model = 1'b0, ns_done_spur = 1'b0;
  logic st_end_model = 1'b0, st_end_spur = 1'b0;
  assign ns_done_stb = ns_done_model | ns_done_spur;
  assign st_end_stb  = st_end_model | st_end_spur;

  int errors = 0, checks = 0, gen = 0;
  logic [31:0] ev_log [0:4095];
  int ev_cnt = 0, ev_rd = 0, mon_viol = 0;
  logic [31:0] exp_q[$];

  always #5 CLK_I = ~CLK_I;

  hd44780_cmd_sequencer #(
    .TIMER_BITS(TB_BITS), .DLY_100MS(D100MS), .DLY_4P1MS(D4P1),
    .DLY_100US(D100US), .DLY_53US(D53), .DLY_3MS(D3MS)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .cmd_dat(cmd_dat), .cmd_rs(cmd_rs),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .init_done(init_done),
    .ns_dat(ns_dat), .ns_rs(ns_rs), .ns_start_stb(ns_start_stb),
    .ns_done_stb(ns_done_stb), .st_dat(st_dat), .st_start_stb(st_start_stb),
    .st_end_stb(st_end_stb)
  );

  function automatic logic [31:0] nyb_ev(input logic [3:0] d, input logic rs);
    return 32'h1000_0000 | {23'd0, rs, 4'd0, d};
  endfunction

  function automatic logic [31:0] tmr_ev(input int v);
    return 32'h2000_0000 | 32'(v);
  endfunction

  // Nybble sender: done strobe 2..5 cycles after each start strobe.
  initial begin : sender_model
    int d, g;
    forever begin
      @(negedge CLK_I);
      if (RST_I && ns_start_stb) begin
        g = gen;
        d = $urandom_range(2, 5);
        repeat (d) @(posedge CLK_I);
        #1;
        if (g == gen && RST_I) begin
          ns_done_model = 1'b1;
          @(posedge CLK_I); #1;
          ns_done_model = 1'b0;
        end
      end
    end
  end

  // State timer: end strobe st_dat cycles after the load strobe.
  initial begin : timer_model
    int v, g;
    forever begin
      @(negedge CLK_I);
      if (RST_I && st_start_stb) begin
        g = gen;
        v = int'(st_dat);
        repeat (v) @(posedge CLK_I);
        #1;
        if (g == gen && RST_I) begin
          st_end_model = 1'b1;
          @(posedge CLK_I); #1;
          st_end_model = 1'b0;
        end
      end
    end
  end

  // Logs every start strobe in order and tallies protocol violations.
  initial begin : monitor
    logic prev_ns, prev_st;
    prev_ns = 1'b0;
    prev_st = 1'b0;
    forever begin
      @(negedge CLK_I);
      if (RST_I) begin
        if (ns_start_stb && st_start_stb) mon_viol++;
        if ((ns_start_stb && prev_ns) || (st_start_stb && prev_st)) mon_viol++;
        if (ns_start_stb && ev_cnt < 4096) begin
          ev_log[ev_cnt] = nyb_ev(ns_dat, ns_rs);
          ev_cnt++;
        end
        if (st_start_stb && ev_cnt < 4096) begin
          ev_log[ev_cnt] = tmr_ev(int'(st_dat));
          ev_cnt++;
        end
      end
      prev_ns = ns_start_stb;
      prev_st = st_start_stb;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic expect_byte(input logic [7:0] b, input logic rs);
    exp_q.push_back(nyb_ev(b[7:4], rs));
    exp_q.push_back(nyb_ev(b[3:0], rs));
    exp_q.push_back(tmr_ev((!rs && b >= 8'h01 && b <= 8'h03) ? D3MS : D53));
  endtask

  task automatic expect_init();
    int nyb [4] = '{3, 3, 3, 2};
    int dly [4] = '{D4P1, D100US, D100US, D100US};
    logic [7:0] ib [5] = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
    exp_q.push_back(tmr_ev(D100MS));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(nyb_ev(4'(nyb[i]), 1'b0));
      exp_q.push_back(tmr_ev(dly[i]));
    end
    for (int i = 0; i < 5; i++) expect_byte(ib[i], 1'b0);
  endtask

  task automatic wait_ready(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK_I);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // Presents one byte; returns at the negedge after the accepting edge.
  task automatic issue(input logic [7:0] b, input logic rs, output bit ok);
    wait_ready(500, ok);
    if (ok) begin
      cmd_dat = b; cmd_rs = rs; cmd_valid = 1'b1;
      @(negedge CLK_I);
      cmd_valid = 1'b0;
      cmd_dat = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    RST_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    checks++;
    if ({cmd_ready, init_done, ns_dat, ns_rs, ns_start_stb, st_dat, st_start_stb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b done=%b ns=%h/%b/%b st=%0d/%b, want all 0",
               cmd_ready, init_done, ns_dat, ns_rs, ns_start_stb, st_dat, st_start_stb);
    end
  endtask

  // Power-on sequence with cmd_valid held high the whole time.
  task automatic test_init_hold_valid();
    logic [7:0] x;
    bit ok;
    x = 8'($urandom);
    cmd_dat = x; cmd_rs = 1'b1; cmd_valid = 1'b1;
    RST_I = 1'b1;
    expect_init();
    wait_ready(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout: cmd_ready never rose, want 1"); end
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b want 1", init_done); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_rd >= ev_cnt) begin
        errors++; $display("FAIL init_stream[%0d]: got none want %h", i, exp_q[i]);
      end else begin
        if (ev_log[ev_rd] !== exp_q[i]) begin
          errors++; $display("FAIL init_stream[%0d]: got %h want %h", i, ev_log[ev_rd], exp_q[i]);
        end
        ev_rd++;
      end
    end
    exp_q.delete();
    // The held request is taken on the first ready edge.
    @(negedge CLK_I);
    cmd_valid = 1'b0;
    checks++;
    if ({ns_start_stb, ns_dat, ns_rs, cmd_ready} !== {1'b1, x[7:4], 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL held_accept: got stb=%b dat=%h rs=%b ready=%b want 1/%h/1/0",
               ns_start_stb, ns_dat, ns_rs, cmd_ready, x[7:4]);
    end
    expect_byte(x, 1'b1);
    wait_ready(500, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_rd >= ev_cnt) begin
        errors++; $display("FAIL held_stream[%0d]: got none want %h", i, exp_q[i]);
      end else begin
        if (ev_log[ev_rd] !== exp_q[i]) begin
          errors++; $display("FAIL held_stream[%0d]: got %h want %h", i, ev_log[ev_rd], exp_q[i]);
        end
        ev_rd++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_latency();
    bit ok, seen, early;
    issue(8'h41, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lat_ready_timeout: got 0 want 1"); end
    checks++;
    if ({ns_start_stb, ns_dat, ns_rs, cmd_ready} !== {1'b1, 4'h4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lat_first_nybble: got stb=%b dat=%h rs=%b ready=%b want 1/4/1/0",
               ns_start_stb, ns_dat, ns_rs, cmd_ready);
    end
    expect_byte(8'h41, 1'b1);
    seen = 1'b0; early = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge CLK_I);
      if (st_end_stb) seen = 1'b1;
      else if (cmd_ready) early = 1'b1;
    end
    checks++;
    if (!seen || early || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat_busy: got end_seen=%b early_ready=%b ready=%b want 1/0/0",
               seen, early, cmd_ready);
    end
    @(negedge CLK_I);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL lat_ready_return: got %b want 1", cmd_ready);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_rd >= ev_cnt) begin
        errors++; $display("FAIL lat_stream[%0d]: got none want %h", i, exp_q[i]);
      end else begin
        if (ev_log[ev_rd] !== exp_q[i]) begin
          errors++; $display("FAIL lat_stream[%0d]: got %h want %h", i, ev_log[ev_rd], exp_q[i]);
        end
        ev_rd++;
      end
    end
    exp_q.delete();
  endtask

  // Fixed corner bytes then random bytes, biased toward the long-delay codes.
  task automatic test_delays();
    logic [7:0] fb [3] = '{8'h01, 8'h01, 8'h04};
    logic       fr [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] b;
    logic       rs;
    bit ok;
    for (int i = 0; i < 15; i++) begin
      if (i < 3) begin
        b = fb[i]; rs = fr[i];
      end else begin
        b  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
        rs = 1'($urandom_range(0, 1));
      end
      issue(b, rs, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL delays_timeout[%0d]: got 0 want 1", i); end
      expect_byte(b, rs);
    end
    wait_ready(500, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_rd >= ev_cnt) begin
        errors++; $display("FAIL delays_stream[%0d]: got none want %h", i, exp_q[i]);
      end else begin
        if (ev_log[ev_rd] !== exp_q[i]) begin
          errors++; $display("FAIL delays_stream[%0d]: got %h want %h", i, ev_log[ev_rd], exp_q[i]);
        end
        ev_rd++;
      end
    end
    exp_q.delete();
  endtask

  // cmd_valid stays high while busy; the second byte waits for ready.
  task automatic test_back_to_back();
    logic [7:0] a, b;
    bit ok;
    a = 8'($urandom); b = 8'($urandom);
    wait_ready(500, ok);
    cmd_dat = a; cmd_rs = 1'b0; cmd_valid = 1'b1;
    @(negedge CLK_I);
    cmd_dat = b; cmd_rs = 1'b1;
    expect_byte(a, 1'b0);
    wait_ready(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got 0 want 1"); end
    @(negedge CLK_I);
    cmd_valid = 1'b0;
    checks++;
    if ({ns_start_stb, ns_dat, ns_rs, cmd_ready} !== {1'b1, b[7:4], 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_accept: got stb=%b dat=%h rs=%b ready=%b want 1/%h/1/0",
               ns_start_stb, ns_dat, ns_rs, cmd_ready, b[7:4]);
    end
    expect_byte(b, 1'b1);
    wait_ready(500, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_rd >= ev_cnt) begin
        errors++; $display("FAIL b2b_stream[%0d]: got none want %h", i, exp_q[i]);
      end else begin
        if (ev_log[ev_rd] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_stream[%0d]: got %h want %h", i, ev_log[ev_rd], exp_q[i]);
        end
        ev_rd++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_spurious();
    logic [7:0] b;
    logic       rs;
    bit ok, seen;
    b = 8'($urandom); rs = 1'($urandom_range(0, 1));
    issue(b, rs, ok);
    expect_byte(b, rs);
    // Timer strobe while waiting on the sender.
    @(posedge CLK_I); #1; st_end_spur = 1'b1;
    @(posedge CLK_I); #1; st_end_spur = 1'b0;
    @(negedge CLK_I);
    checks++;
    if ({ns_start_stb, st_start_stb} !== 2'b00) begin
      errors++;
      $display("FAIL spur_st_end: got ns_stb=%b st_stb=%b want 0/0", ns_start_stb, st_start_stb);
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK_I);
      if (st_start_stb) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL spur_dly_timeout: got 0 want 1"); end
    // Sender strobe while waiting on the timer.
    @(posedge CLK_I); #1; ns_done_spur = 1'b1;
    @(posedge CLK_I); #1; ns_done_spur = 1'b0;
    @(negedge CLK_I);
    checks++;
    if ({cmd_ready, ns_start_stb} !== 2'b00) begin
      errors++;
      $display("FAIL spur_ns_done: got ready=%b ns_stb=%b want 0/0", cmd_ready, ns_start_stb);
    end
    wait_ready(500, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_rd >= ev_cnt) begin
        errors++; $display("FAIL spur_stream[%0d]: got none want %h", i, exp_q[i]);
      end else begin
        if (ev_log[ev_rd] !== exp_q[i]) begin
          errors++; $display("FAIL spur_stream[%0d]: got %h want %h", i, ev_log[ev_rd], exp_q[i]);
        end
        ev_rd++;
      end
    end
    exp_q.delete();
  endtask

  // Reset during HI_WAIT of the 0x06 init byte, then a full restart.
  task automatic test_reset_mid();
    int cnt;
    bit ok;
    RST_I = 1'b0; gen++;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    expect_init();
    cnt = 0;
    for (int i = 0; i < 2000 && cnt < 19; i++) begin
      @(negedge CLK_I);
      if (ns_start_stb) cnt++;
      if (st_start_stb) cnt++;
    end
    checks++;
    if (cnt != 19) begin errors++; $display("FAIL rstmid_reach: got %0d strobes want 19", cnt); end
    @(posedge CLK_I); #2;
    RST_I = 1'b0; gen++;
    #1;
    checks++;
    if ({cmd_ready, init_done, ns_dat, ns_rs, ns_start_stb, st_dat, st_start_stb} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got ready=%b done=%b ns=%h/%b/%b st=%0d/%b, want all 0",
               cmd_ready, init_done, ns_dat, ns_rs, ns_start_stb, st_dat, st_start_stb);
    end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (ev_rd >= ev_cnt) begin
        errors++; $display("FAIL rstmid_prefix[%0d]: got none want %h", i, exp_q[i]);
      end else begin
        if (ev_log[ev_rd] !== exp_q[i]) begin
          errors++; $display("FAIL rstmid_prefix[%0d]: got %h want %h", i, ev_log[ev_rd], exp_q[i]);
        end
        ev_rd++;
      end
    end
    exp_q.delete();
    ev_rd = ev_cnt;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    checks++;
    if ({st_start_stb, st_dat} !== {1'b1, TB_BITS'(D100MS)}) begin
      errors++;
      $display("FAIL rstmid_restart: got stb=%b dat=%0d want 1/%0d", st_start_stb, st_dat, D100MS);
    end
    expect_init();
    wait_ready(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: got 0 want 1"); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_rd >= ev_cnt) begin
        errors++; $display("FAIL rstmid_stream[%0d]: got none want %h", i, exp_q[i]);
      end else begin
        if (ev_log[ev_rd] !== exp_q[i]) begin
          errors++; $display("FAIL rstmid_stream[%0d]: got %h want %h", i, ev_log[ev_rd], exp_q[i]);
        end
        ev_rd++;
      end
    end
    exp_q.delete();
  endtask

  initial begin : main
    test_reset();
    test_init_hold_valid();
    test_latency();
    test_delays();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    checks++;
    if (ev_cnt != ev_rd) begin
      errors++; $display("FAIL extra_strobes: got %0d logged want %0d", ev_cnt, ev_rd);
    end
    checks++;
    if (mon_viol != 0) begin
      errors++; $display("FAIL strobe_protocol: got %0d violations want 0", mon_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
